// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Constants and types shared by the instruction-fetch slice.
//   NOP_INST         : RV32I "addi x0,x0,0". The output stage holds this word
//                      while it is empty after reset.
//   PC_INC           : byte stride between sequential instruction words.
//   RESET_PC_DEFAULT : default first fetch address after reset.
//   fetch_entry_t    : {pc, inst} pair that moves through skid and output stage.
//   align_pc()       : forces a byte address onto a word boundary.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Groups the fetch unit's ROM bus and decode-side signals.
//   IMEM_ADDR   : fetch -> ROM, byte address (registered in the fetch unit)
//   IMEM_INST   : ROM -> fetch, word for the address of the previous cycle
//   stall       : decode -> fetch, decode cannot accept this cycle
//   redirect    : decode -> fetch, taken branch/jump (one-cycle pulse)
//   redirect_pc : decode -> fetch, branch/jump target
//   if_valid    : fetch -> decode, if_pc/if_inst hold a live instruction
//   if_pc       : fetch -> decode, address of the presented instruction
//   if_inst     : fetch -> decode, presented instruction word
// Modport master is the fetch unit's view; modport slave is the view of the
// ROM and decode stage.
// -----------------------------------------------------------------------------
interface inst_fetch_if;

   logic [31:0] IMEM_ADDR;
   logic [31:0] IMEM_INST;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   modport master (
      output IMEM_ADDR, if_valid, if_pc, if_inst,
      input  IMEM_INST, stall, redirect, redirect_pc
   );

   modport slave (
      input  IMEM_ADDR, if_valid, if_pc, if_inst,
      output IMEM_INST, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry skid buffer. It catches a ROM word that arrives while the output
// stage is full and held by a stall.
//   clk_50    : clock
//   rst_n     : asynchronous active-low reset (empties the buffer)
//   flush     : synchronous clear on redirect (takes priority over push)
//   push      : capture push_data
//   push_data : {pc, inst} of the arriving word
//   pop       : the output stage takes the held entry
//   valid     : an entry is held
//   data      : held {pc, inst}
// -----------------------------------------------------------------------------
module fetch_skid
   import cpu_pkg::*;
(
   input  logic         clk_50,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic         valid,
   output fetch_entry_t data
);

   logic         valid_q, valid_d;
   fetch_entry_t data_q, data_d;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (push) begin
         valid_d = 1'b1;
         data_d  = push_data;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments, so
   // every flop samples values from before the edge.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // NOTE: the payload has no reset. It is never read while valid_q is 0, so
   // only the valid bit has to come out of reset in a known state.
   always_ff @(posedge clk_50) begin
      data_q <= data_d;
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// In-order instruction fetch for a 1-cycle-latency synchronous ROM.
// The PC register drives the ROM address directly. A request tag (req_v/req_pc)
// follows each issued address by one cycle. A registered output stage presents
// the instruction, and a one-entry skid catches the word that is already in
// flight when decode stalls. A redirect flushes everything and refetches from
// the word-aligned target.
//   clk_50 : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : inst_fetch_if.master (ROM address/data, stall, redirect, if_* out)
// Parameter RESET_PC: first fetch address after reset (word aligned).
// -----------------------------------------------------------------------------
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic         clk_50,
   input  logic         rst_n,
   inst_fetch_if.master bus
);

   logic [31:0]  pc_q, pc_d;
   logic         req_v_q, req_v_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         if_valid_q, if_valid_d;
   fetch_entry_t if_entry_q, if_entry_d;

   logic         issue, consume, load_out;
   logic         skid_push, skid_pop, skid_valid;
   fetch_entry_t arr_entry, skid_data;

   always_comb begin
      issue     = ~bus.stall & ~bus.redirect;
      consume   = if_valid_q & ~bus.stall;
      load_out  = ~if_valid_q | consume;
      arr_entry = '{pc: req_pc_q, inst: bus.IMEM_INST};
      // The arriving word parks in the skid only when the output stage cannot
      // take it. A stall also blocks issue, so the next cycle brings no word
      // and the single entry is enough.
      skid_push = req_v_q & if_valid_q & ~consume;
      skid_pop  = load_out & skid_valid;

      pc_d       = pc_q;
      req_v_d    = issue;
      req_pc_d   = pc_q;
      if_valid_d = if_valid_q;
      if_entry_d = if_entry_q;

      if (bus.redirect) begin
         pc_d       = align_pc(bus.redirect_pc);
         if_valid_d = 1'b0;
      end else begin
         if (issue) begin
            pc_d = pc_q + PC_INC;
         end
         // The skid word is older than the arriving word, so it goes first
         // to keep address order.
         if (load_out) begin
            if (skid_valid) begin
               if_valid_d = 1'b1;
               if_entry_d = skid_data;
            end else if (req_v_q) begin
               if_valid_d = 1'b1;
               if_entry_d = arr_entry;
            end else begin
               if_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_v_q    <= 1'b0;
         req_pc_q   <= '0;
         if_valid_q <= 1'b0;
         if_entry_q <= '{pc: 32'h0, inst: NOP_INST};
      end else begin
         pc_q       <= pc_d;
         req_v_q    <= req_v_d;
         req_pc_q   <= req_pc_d;
         if_valid_q <= if_valid_d;
         if_entry_q <= if_entry_d;
      end
   end

   fetch_skid u_skid (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .flush     (bus.redirect),
      .push      (skid_push),
      .push_data (arr_entry),
      .pop       (skid_pop),
      .valid     (skid_valid),
      .data      (skid_data)
   );

   // A full skid must never meet an arriving word; the word would be lost.
   a_skid_no_overflow: assert property (
      @(posedge clk_50) disable iff (!rst_n) !(skid_valid && req_v_q)
   );

   assign bus.IMEM_ADDR = pc_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_pc     = if_entry_q.pc;
   assign bus.if_inst   = if_entry_q.inst;

endmodule
